jt12_eg_kon: RTL and testbench

- Key-on sequencer for the time-multiplexed envelope generator.
- Holds the 24 per-operator key states written by the CPU through the key register (0x28).
- Steps a 24-slot operator counter and emits one-cycle keyon_II/keyoff_II strobes on state edges, aligned to the operator currently entering EG stage II.
- Also generates the `zero` frame pulse and the slot/channel/operator indices used by the rest of the FM core.

---
 rtl/jt12_eg_kon.sv | 158 +++++++++++++++
 tb/tb_jt12_eg_kon.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/jt12_eg_kon.sv
`default_nettype none
// ============================================================================
// Module   : jt12_eg_kon
// Purpose  : Key-on sequencer for the time-multiplexed envelope generator.
//            Holds the 24 per-operator key states written through the key
//            register (0x28). It steps a 24-slot operator counter and raises
//            one-cycle keyon_II / keyoff_II strobes when the key state of the
//            slot now entering EG stage II has changed since its last visit.
//            It also produces the `zero` frame pulse and the slot, channel and
//            operator indices used by the rest of the FM core.
// Ports    : clk, rst        clock, synchronous active-high reset
//            cen             clock enable; slot and edge history advance only
//                            when high
//            wr_kon, din     key-register write strobe and data
//                            (din[7:4] operator mask S1,S2,S3,S4; din[2:0]
//                            channel code)
//            slot, ch, op    current stage-II slot and its channel/operator
//            keyon_II        key-on edge strobe for the current slot
//            keyoff_II       key-off edge strobe for the current slot
//            zero            frame pulse at slot ZERO_SLOT
//            kon_state       current key-state register
// Revision : 1.0 - initial release
// ============================================================================
module jt12_eg_kon #(
    parameter int ZERO_SLOT = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr_kon,
    input  logic [7:0]  din,
    output logic [4:0]  slot,
    output logic [2:0]  ch,
    output logic [1:0]  op,
    output logic        keyon_II,
    output logic        keyoff_II,
    output logic        zero,
    output logic [23:0] kon_state
);

    localparam logic [4:0]  c_last_slot = 5'd23;
    localparam logic [4:0]  c_zero_slot = ZERO_SLOT[4:0];
    // Bits 0, 6, 12 and 18: the four operator slots of channel 0.
    localparam logic [23:0] c_ch0_mask  = 24'h041041;

    logic [4:0]  r_slot;
    logic [23:0] r_kon_cur;
    logic [23:0] r_kon_last;

    // ------------------------------------------------------------------------
    // Slot decode. Slots are grouped in blocks of six channels, with the
    // groups in operator order S1, S3, S2, S4.
    // ------------------------------------------------------------------------
    logic [1:0] w_grp;
    logic [2:0] w_grp_base;

    always_comb begin
        w_grp      = 2'd3;
        w_grp_base = 3'd2;          // 18 mod 8
        if (r_slot < 5'd6) begin
            w_grp      = 2'd0;
            w_grp_base = 3'd0;
        end else if (r_slot < 5'd12) begin
            w_grp      = 2'd1;
            w_grp_base = 3'd6;
        end else if (r_slot < 5'd18) begin
            w_grp      = 2'd2;
            w_grp_base = 3'd4;      // 12 mod 8
        end
    end

    // The channel is below 6, so subtracting the group base modulo 8 on the
    // low three bits gives slot mod 6 without a full-width subtractor.
    logic [2:0] w_ch;
    assign w_ch = r_slot[2:0] - w_grp_base;

    // Group order S1,S3,S2,S4 maps to operator 0,2,1,3: swap the group bits.
    logic [1:0] w_op;
    assign w_op = {w_grp[0], w_grp[1]};

    // ------------------------------------------------------------------------
    // Key-register write decode. Codes 3 and 7 do not address a channel and
    // the whole write is dropped. din[3] carries no meaning.
    // ------------------------------------------------------------------------
    logic       w_wr_valid;
    logic [2:0] w_wr_ch;
    logic       w_unused_din3;

    assign w_unused_din3 = din[3];
    assign w_wr_valid    = wr_kon && (din[1:0] != 2'b11);
    assign w_wr_ch       = {1'b0, din[1:0]} + (din[2] ? 3'd3 : 3'd0);

    // Operator bits placed at their channel-0 slot positions (S1 at 0, S3 at
    // 6, S2 at 12, S4 at 18), then shifted to the addressed channel.
    logic [23:0] w_wr_val_ch0;
    logic [23:0] w_wr_mask;
    logic [23:0] w_wr_val;

    assign w_wr_val_ch0 = {5'd0, din[7], 5'd0, din[5], 5'd0, din[6], 5'd0, din[4]};
    assign w_wr_mask    = c_ch0_mask << w_wr_ch;
    assign w_wr_val     = w_wr_val_ch0 << w_wr_ch;

    // ------------------------------------------------------------------------
    // Edge detection on the slot being evaluated. Both values come from
    // registers, so a write landing in this cycle is not seen until the
    // slot's next visit.
    // ------------------------------------------------------------------------
    logic [23:0] w_slot_1h;
    logic        w_cur_bit;
    logic        w_last_bit;

    assign w_slot_1h  = 24'd1 << r_slot;
    assign w_cur_bit  = |(r_kon_cur  & w_slot_1h);
    assign w_last_bit = |(r_kon_last & w_slot_1h);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= 5'd0;
        end else if (cen) begin
            r_slot <= (r_slot == c_last_slot) ? 5'd0 : r_slot + 5'd1;
        end
    end

    // Writes are taken regardless of cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kon_cur <= 24'd0;
        end else if (w_wr_valid) begin
            r_kon_cur <= (r_kon_cur & ~w_wr_mask) | (w_wr_val & w_wr_mask);
        end
    end

    // History is captured from the pre-write state, so a key toggled on and
    // back off before its slot comes round leaves no strobe behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kon_last <= 24'd0;
        end else if (cen) begin
            r_kon_last <= (r_kon_last & ~w_slot_1h) | (r_kon_cur & w_slot_1h);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign slot      = r_slot;
    assign ch        = w_ch;
    assign op        = w_op;
    assign keyon_II  = cen &  w_cur_bit & ~w_last_bit;
    assign keyoff_II = cen & ~w_cur_bit &  w_last_bit;
    assign zero      = cen & (r_slot == c_zero_slot);
    assign kon_state = r_kon_cur;

endmodule
`default_nettype wire

// File: tb/tb_jt12_eg_kon.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt12_eg_kon
// Purpose  : Directed self-checking bench for jt12_eg_kon. Inputs are driven
//            1 time unit after each rising edge and outputs are compared
//            1 unit later, well away from the next active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt12_eg_kon;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        wr_kon;
    logic [7:0]  din;
    logic [4:0]  slot;
    logic [2:0]  ch;
    logic [1:0]  op;
    logic        keyon_II;
    logic        keyoff_II;
    logic        zero;
    logic [23:0] kon_state;

    int n_checks = 0;
    int n_errors = 0;
    int exp_slot = 0;

    jt12_eg_kon #(.ZERO_SLOT(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .wr_kon    (wr_kon),
        .din       (din),
        .slot      (slot),
        .ch        (ch),
        .op        (op),
        .keyon_II  (keyon_II),
        .keyoff_II (keyoff_II),
        .zero      (zero),
        .kon_state (kon_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the expected slot follows the enable seen at the edge.
    task automatic tick();
        logic en;
        en = cen;
        @(posedge clk);
        #1;
        if (en) exp_slot = (exp_slot == 23) ? 0 : exp_slot + 1;
    endtask

    // Run n enabled cycles. on_mask/off_mask mark slots expected to strobe
    // once; each bit is retired after its first visit.
    task automatic run(input int n, input logic [23:0] on_mask, input logic [23:0] off_mask);
        logic [23:0] on_left;
        logic [23:0] off_left;
        logic [1:0]  op_tab [4];
        op_tab = '{2'd0, 2'd2, 2'd1, 2'd3};
        on_left  = on_mask;
        off_left = off_mask;
        for (int i = 0; i < n; i++) begin
            #1;
            check("slot",      32'(slot),      32'(exp_slot));
            check("ch",        32'(ch),        32'(exp_slot % 6));
            check("op",        32'(op),        32'(op_tab[exp_slot / 6]));
            check("zero",      32'(zero),      32'(exp_slot == 23));
            check("keyon_II",  32'(keyon_II),  32'(on_left[exp_slot]));
            check("keyoff_II", 32'(keyoff_II), 32'(off_left[exp_slot]));
            on_left[exp_slot]  = 1'b0;
            off_left[exp_slot] = 1'b0;
            tick();
        end
    endtask

    // One-cycle key-register write; the slot evaluated in that cycle must
    // not strobe from stale history either.
    task automatic write_kon(input logic [7:0] d);
        wr_kon = 1'b1;
        din    = d;
        #1;
        check("wr_no_on",  32'(keyon_II),  32'd0);
        check("wr_no_off", 32'(keyoff_II), 32'd0);
        tick();
        wr_kon = 1'b0;
        din    = 8'h00;
    endtask

    initial begin
        rst    = 1'b1;
        cen    = 1'b0;
        wr_kon = 1'b0;
        din    = 8'h00;
        tick();
        tick();
        rst      = 1'b0;
        exp_slot = 0;
        #1;
        check("rst_slot",      32'(slot),      32'd0);
        check("rst_kon_state", 32'(kon_state), 32'd0);
        check("rst_keyon",     32'(keyon_II),  32'd0);
        check("rst_keyoff",    32'(keyoff_II), 32'd0);
        check("rst_zero",      32'(zero),      32'd0);

        // Two idle frames; explicit spot checks on the group order.
        cen = 1'b1;
        repeat (6) tick();
        check("slot6_ch",  32'(ch), 32'd0);
        check("slot6_op",  32'(op), 32'd2);
        repeat (7) tick();
        check("slot13_ch", 32'(ch), 32'd1);
        check("slot13_op", 32'(op), 32'd1);
        repeat (11) tick();
        run(24, 24'h0, 24'h0);
        run(24, 24'h0, 24'h0);

        // All operators of ch1 on, written at slot 0.
        check("at_slot0", 32'(slot), 32'd0);
        write_kon(8'hF1);
        check("kon_all_ch1", 32'(kon_state), 32'h082082);
        run(48, 24'h082082, 24'h0);

        // All operators of ch1 off (written at slot 1).
        write_kon(8'h01);
        check("kon_clear", 32'(kon_state), 32'h0);
        run(48, 24'h0, 24'h082082);

        // Invalid channel codes 3 and 7 are dropped entirely.
        write_kon(8'h13);
        write_kon(8'h97);
        check("kon_invalid", 32'(kon_state), 32'h0);
        run(48, 24'h0, 24'h0);

        // ch3 S1 -> slot 3.
        write_kon(8'h14);
        check("kon_ch3", 32'(kon_state), 32'h000008);
        run(48, 24'h000008, 24'h0);

        // Collision: write ch2 S1 while slot 2 is being evaluated.
        run(24 - ((exp_slot + 22) % 24), 24'h0, 24'h0);
        check("at_slot2", 32'(slot), 32'd2);
        write_kon(8'h12);
        check("kon_ch2", 32'(kon_state), 32'h00000C);
        run(24, 24'h000004, 24'h0);

        // Pending ch0 S1 edge held across a cen=0 stall at slot 23.
        write_kon(8'h10);
        check("kon_ch0", 32'(kon_state), 32'h00000D);
        run(23 - exp_slot, 24'h0, 24'h0);
        cen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_slot",  32'(slot),      32'd23);
            check("stall_keyon", 32'(keyon_II),  32'd0);
            check("stall_zero",  32'(zero),      32'd0);
            tick();
        end
        cen = 1'b1;
        run(24, 24'h000001, 24'h0);

        // Reset mid-frame with keys on: no key-off afterwards.
        run(5, 24'h0, 24'h0);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        exp_slot = 0;
        #1;
        check("rst2_slot",      32'(slot),      32'd0);
        check("rst2_kon_state", 32'(kon_state), 32'h0);
        check("rst2_keyon",     32'(keyon_II),  32'd0);
        check("rst2_keyoff",    32'(keyoff_II), 32'd0);
        check("rst2_zero",      32'(zero),      32'd0);
        run(48, 24'h0, 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
